// File: rtl/lc3b_types.sv
// Purpose: shared LC-3b memory-stage types (memory op codes, MEM FSM states).
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lc3b_types;

   typedef enum logic [2:0] {
      MOP_NONE = 3'd0,
      MOP_LD   = 3'd1,
      MOP_ST   = 3'd2,
      MOP_LDB  = 3'd3,
      MOP_STB  = 3'd4,
      MOP_LDI  = 3'd5,
      MOP_STI  = 3'd6
   } lc3b_mem_op;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC1 = 2'd1,
      ACC2 = 2'd2,
      DONE = 2'd3
   } mem_state;

   // Byte-granular ops select a single lane; every other op is a full word.
   function automatic logic is_byte_op(input logic [2:0] op);
      return (op == MOP_LDB) || (op == MOP_STB);
   endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Purpose: byte-lane steering: lane enables, replicated store data, zero-extended load byte.
// Latency: combinational.
// Backpressure: none.
module mem_byte_lane
   import lc3b_types::*;
#(
   parameter int DATA_W = 16,
   parameter int LANE_W = 1
) (
   input  logic [LANE_W-1:0]   lane,
   input  logic [2:0]          op,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W-1:0]   rdata,
   output logic [DATA_W/8-1:0] byte_enable,
   output logic [DATA_W-1:0]   store_data,
   output logic [DATA_W-1:0]   load_data
);

   localparam int LANES = DATA_W / 8;

   logic [LANE_W-1:0] lane_idx;
   logic [7:0]        sel_byte;

   // A single-lane bus has no lane bits worth honouring.
   assign lane_idx = (LANES > 1) ? lane : '0;
   assign sel_byte = rdata[lane_idx*8 +: 8];

   // Word ops pass through untouched; byte ops steer onto one lane.
   always_comb begin
      byte_enable = '1;
      store_data  = wdata;
      load_data   = rdata;
      if (is_byte_op(op)) begin
         byte_enable           = '0;
         byte_enable[lane_idx] = 1'b1;
         store_data            = {LANES{wdata[7:0]}};
         load_data             = '0;
         load_data[7:0]        = sel_byte;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// Purpose: LC-3b MEM stage; runs word/byte/indirect accesses and registers the MEM/WB result.
// Latency: non-memory op 1 cycle; memory op 1 cycle to request, result 1 cycle after final mem_resp.
// Backpressure: in_ready low (stall_out high) from capture through the result pulse; in_valid ignored then.
module mem_access_stage
   import lc3b_types::*;
#(
   parameter int DATA_W          = 16,
   parameter int ADDR_W          = 16,
   parameter int ENABLE_INDIRECT = 1,
   parameter int MAX_WAIT        = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [2:0]          in_op,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [DATA_W-1:0]   in_wdata,
   input  logic [ADDR_W-1:0]   in_npc,
   input  logic [DATA_W-1:0]   in_aluresult,
   input  logic [15:0]         in_ir,
   input  logic [2:0]          in_drid,
   output logic                in_ready,
   output logic                stall_out,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_byte_enable,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_resp,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data,
   output logic [ADDR_W-1:0]   out_addr,
   output logic [ADDR_W-1:0]   out_npc,
   output logic [DATA_W-1:0]   out_aluresult,
   output logic [15:0]         out_ir,
   output logic [2:0]          out_drid,
   output logic                out_err
);

   localparam int                LANES     = DATA_W / 8;
   localparam int                LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(LANES - 1);
   localparam int                CNT_W     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CNT_W-1:0]  LAST_WAIT = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : CNT_W'(0);

   typedef struct packed {
      lc3b_mem_op        op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [ADDR_W-1:0] npc;
      logic [DATA_W-1:0] aluresult;
      logic [15:0]       ir;
      logic [2:0]        drid;
   } ex_mem_t;

   mem_state            state, state_nxt;
   ex_mem_t             cap;
   logic [ADDR_W-1:0]   ptr_q;
   logic [CNT_W-1:0]    wait_q;
   logic [DATA_W-1:0]   out_data_q;
   logic [ADDR_W-1:0]   out_addr_q;
   logic                out_err_q;

   lc3b_mem_op          in_op_dec;
   logic                indirect_op, load_op, in_acc, timeout_hit;
   logic [DATA_W/8-1:0] lane_be;
   logic [DATA_W-1:0]   lane_wdata, lane_rdata;
   logic [ADDR_W-1:0]   req_addr;

   // Undefined op encodings are treated as a plain passthrough.
   assign in_op_dec   = (in_op > 3'd6) ? MOP_NONE : lc3b_mem_op'(in_op);
   assign indirect_op = (ENABLE_INDIRECT != 0) && ((cap.op == MOP_LDI) || (cap.op == MOP_STI));
   assign load_op     = (cap.op == MOP_LD) || (cap.op == MOP_LDB) || (cap.op == MOP_LDI);
   assign in_acc      = (state == ACC1) || (state == ACC2);
   // A response in the final wait cycle beats the timeout.
   assign timeout_hit = (MAX_WAIT > 0) && in_acc && !mem_resp && (wait_q == LAST_WAIT);

   mem_byte_lane #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W)
   ) u_lane (
      .lane        (cap.addr[LANE_W-1:0]),
      .op          (cap.op),
      .wdata       (cap.wdata),
      .rdata       (mem_rdata),
      .byte_enable (lane_be),
      .store_data  (lane_wdata),
      .load_data   (lane_rdata)
   );

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state: one or two accesses, each ending on mem_resp or timeout, then a result cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = (in_op_dec == MOP_NONE) ? DONE : ACC1;
         ACC1: begin
            if (mem_resp)         state_nxt = indirect_op ? ACC2 : DONE;
            else if (timeout_hit) state_nxt = DONE;
         end
         ACC2: if (mem_resp || timeout_hit) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from registered state only, so requests stay steady while waiting.
   always_comb begin
      in_ready        = (state == IDLE);
      stall_out       = (state != IDLE);
      out_valid       = (state == DONE);
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      req_addr        = '0;
      mem_wdata       = '0;
      mem_byte_enable = '0;
      case (state)
         ACC1: begin
            // The indirect pointer fetch is always a word read, even for STI.
            req_addr        = is_byte_op(cap.op) ? cap.addr : (cap.addr & ~LOW_MASK);
            mem_byte_enable = lane_be;
            mem_wdata       = lane_wdata;
            mem_read        = load_op || indirect_op;
            mem_write       = !(load_op || indirect_op);
         end
         ACC2: begin
            req_addr        = ptr_q;
            mem_byte_enable = '1;
            mem_wdata       = cap.wdata;
            mem_read        = (cap.op == MOP_LDI);
            mem_write       = (cap.op == MOP_STI);
         end
         default: ;
      endcase
      mem_address = req_addr;
   end

   // Capture the EX/MEM bundle, track waits, and register the final result.
   always_ff @(posedge clk) begin
      if (reset) begin
         cap        <= '0;
         ptr_q      <= '0;
         wait_q     <= '0;
         out_data_q <= '0;
         out_addr_q <= '0;
         out_err_q  <= 1'b0;
      end else begin
         wait_q <= (in_acc && !mem_resp) ? wait_q + 1'b1 : '0;
         case (state)
            IDLE: if (in_valid) begin
               cap <= '{op: in_op_dec, addr: in_addr, wdata: in_wdata, npc: in_npc,
                        aluresult: in_aluresult, ir: in_ir, drid: in_drid};
               out_data_q <= '0;
               out_err_q  <= 1'b0;
               out_addr_q <= in_addr;
            end
            ACC1, ACC2: begin
               if (mem_resp) begin
                  if ((state == ACC1) && indirect_op) begin
                     ptr_q <= ADDR_W'(mem_rdata) & ~LOW_MASK;
                  end else begin
                     out_addr_q <= req_addr;
                     out_data_q <= load_op ? lane_rdata : '0;
                  end
               end else if (timeout_hit) begin
                  out_err_q  <= 1'b1;
                  out_addr_q <= req_addr;
                  out_data_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_data      = out_data_q;
   assign out_addr      = out_addr_q;
   assign out_err       = out_err_q;
   assign out_npc       = cap.npc;
   assign out_aluresult = cap.aluresult;
   assign out_ir        = cap.ir;
   assign out_drid      = cap.drid;

endmodule

// File: tb/tb_mem_access_stage.sv
// Purpose: self-checking bench for mem_access_stage with a reactive memory and reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_stage;
   import lc3b_types::*;

   localparam int MAXW = 4;

   logic        clk, reset, in_valid;
   logic [2:0]  in_op;
   logic [15:0] in_addr, in_wdata, in_npc, in_aluresult, in_ir;
   logic [2:0]  in_drid;
   logic        in_ready, stall_out, mem_read, mem_write, mem_resp, out_valid, out_err;
   logic [15:0] mem_address, mem_wdata, mem_rdata, out_data, out_addr, out_npc, out_aluresult, out_ir;
   logic [1:0]  mem_byte_enable;
   logic [2:0]  out_drid;

   int n_vec = 0;
   int n_bad = 0;

   mem_access_stage #(.DATA_W(16), .ADDR_W(16), .ENABLE_INDIRECT(1), .MAX_WAIT(MAXW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_npc(in_npc), .in_aluresult(in_aluresult), .in_ir(in_ir),
      .in_drid(in_drid), .in_ready(in_ready), .stall_out(stall_out), .mem_read(mem_read),
      .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr), .out_npc(out_npc),
      .out_aluresult(out_aluresult), .out_ir(out_ir), .out_drid(out_drid), .out_err(out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed transaction trace
   int          obs_nacc, obs_lat;
   logic        obs_valid, obs_stall_bad, obs_unstable, obs_both, obs_extra, post_valid, post_ready;
   logic        obs_rd[2], obs_wr[2];
   logic [15:0] obs_addr[2], obs_wd[2];
   logic [1:0]  obs_be[2];
   int          obs_len[2];
   logic [15:0] o_data, o_addr, o_npc, o_alu, o_ir;
   logic [2:0]  o_drid;
   logic        o_err;

   // Reference model expectations
   int          exp_nacc, exp_lat;
   logic        exp_err;
   logic [15:0] exp_data, exp_oaddr;
   logic        exp_rd[2], exp_wr[2];
   logic [15:0] exp_addr[2], exp_wd[2];
   logic [1:0]  exp_be[2];
   int          exp_len[2];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one instruction and act as memory: response after d wait cycles (d >= MAXW never answers).
   task automatic run_txn(input logic [2:0] op, input logic [15:0] addr, wdata, npc, alu, ir,
                          input logic [2:0] drid, input int d1, d2, input logic [15:0] r1, r2,
                          input bit garbage);
      int acc, w, dly;
      logic [15:0] rv;
      in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata;
      in_npc = npc; in_aluresult = alu; in_ir = ir; in_drid = drid;
      tick();
      if (garbage) begin
         in_op = MOP_STB; in_addr = ~addr; in_wdata = ~wdata; in_npc = ~npc;
         in_aluresult = ~alu; in_ir = ~ir; in_drid = ~drid;
      end else begin
         in_valid = 1'b0;
      end
      acc = 0; w = 0; obs_nacc = 0; obs_lat = -1; obs_valid = 0;
      obs_stall_bad = 0; obs_unstable = 0; obs_both = 0; obs_extra = 0;
      for (int k = 0; k < 2; k++) begin
         obs_rd[k] = 0; obs_wr[k] = 0; obs_addr[k] = '0; obs_wd[k] = '0; obs_be[k] = '0; obs_len[k] = 0;
      end
      for (int c = 0; c < 40 && !obs_valid; c++) begin
         if (stall_out !== !in_ready) obs_stall_bad = 1;
         if (out_valid === 1'b1) begin
            obs_valid = 1; obs_lat = c;
            o_data = out_data; o_addr = out_addr; o_npc = out_npc; o_alu = out_aluresult;
            o_ir = out_ir; o_drid = out_drid; o_err = out_err;
            if (in_ready !== 1'b0) obs_stall_bad = 1;
            in_valid = 1'b0;
            mem_resp = 1'($urandom);   // stray response outside an access
            mem_rdata = 16'($urandom);
         end else begin
            if (in_ready !== 1'b0) obs_stall_bad = 1;
            if (mem_read === 1'b1 || mem_write === 1'b1) begin
               if (mem_read === 1'b1 && mem_write === 1'b1) obs_both = 1;
               if (acc > 1) obs_extra = 1;
               else if (w == 0) begin
                  obs_rd[acc] = mem_read; obs_wr[acc] = mem_write; obs_addr[acc] = mem_address;
                  obs_wd[acc] = mem_wdata; obs_be[acc] = mem_byte_enable; obs_nacc = acc + 1;
               end else if (mem_read !== obs_rd[acc] || mem_write !== obs_wr[acc] ||
                            mem_address !== obs_addr[acc] || mem_wdata !== obs_wd[acc] ||
                            mem_byte_enable !== obs_be[acc]) obs_unstable = 1;
               dly = (acc == 0) ? d1 : d2;
               rv  = (acc == 0) ? r1 : r2;
               mem_resp  = (w == dly);
               mem_rdata = (w == dly) ? rv : 16'($urandom);
               w++;
               if (acc < 2) obs_len[acc] = w;
               if (mem_resp) begin acc++; w = 0; end
            end else begin
               if (w != 0) begin acc++; w = 0; end
               mem_resp = 1'b0;
            end
         end
         tick();
      end
      post_valid = out_valid; post_ready = in_ready;
      mem_resp = 1'b0; in_valid = 1'b0;
   endtask

   // Reference: list the accesses the op implies, then walk them with the memory's delays.
   task automatic predict(input logic [2:0] op, input logic [15:0] addr, wdata,
                          input int d1, d2, input logic [15:0] r1, r2);
      logic [15:0] wa;
      logic [1:0]  bbe;
      int          pn, dly;
      wa  = {addr[15:1], 1'b0};
      bbe = addr[0] ? 2'b10 : 2'b01;
      for (int k = 0; k < 2; k++) begin
         exp_rd[k] = 0; exp_wr[k] = 0; exp_addr[k] = '0; exp_wd[k] = '0; exp_be[k] = '0; exp_len[k] = 0;
      end
      pn = 0;
      case (op)
         MOP_LD:  begin pn = 1; exp_rd[0] = 1; exp_addr[0] = wa;   exp_be[0] = 2'b11; end
         MOP_LDB: begin pn = 1; exp_rd[0] = 1; exp_addr[0] = addr; exp_be[0] = bbe; end
         MOP_ST:  begin pn = 1; exp_wr[0] = 1; exp_addr[0] = wa;   exp_be[0] = 2'b11; exp_wd[0] = wdata; end
         MOP_STB: begin pn = 1; exp_wr[0] = 1; exp_addr[0] = addr; exp_be[0] = bbe; exp_wd[0] = {wdata[7:0], wdata[7:0]}; end
         MOP_LDI, MOP_STI: begin
            pn = 2; exp_rd[0] = 1; exp_addr[0] = wa; exp_be[0] = 2'b11;
            exp_addr[1] = {r1[15:1], 1'b0}; exp_be[1] = 2'b11; exp_wd[1] = wdata;
            exp_rd[1] = (op == MOP_LDI); exp_wr[1] = (op == MOP_STI);
         end
         default: pn = 0;
      endcase
      exp_nacc = 0; exp_lat = 0; exp_err = 0; exp_oaddr = addr;
      for (int k = 0; k < pn; k++) begin
         dly = (k == 0) ? d1 : d2;
         if (!exp_err) begin
            exp_nacc++;
            exp_len[k] = (dly < MAXW) ? dly + 1 : MAXW;
            exp_lat += exp_len[k];
            exp_oaddr = exp_addr[k];
            if (dly >= MAXW) exp_err = 1;
         end
      end
      exp_data = '0;
      if (!exp_err) begin
         if (op == MOP_LD)  exp_data = r1;
         if (op == MOP_LDI) exp_data = r2;
         if (op == MOP_LDB) exp_data = addr[0] ? {8'h00, r1[15:8]} : {8'h00, r1[7:0]};
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; tick(); tick();
      n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_vec++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall_out); end
      n_vec++; if ({mem_read, mem_write, out_valid, out_err} !== 4'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 0000", {mem_read, mem_write, out_valid, out_err}); end
      n_vec++; if ({mem_address, mem_wdata, mem_byte_enable} !== '0) begin n_bad++; $display("FAIL reset_mem: got %h/%h/%b want 0", mem_address, mem_wdata, mem_byte_enable); end
      n_vec++; if ({out_data, out_addr, out_npc, out_aluresult, out_ir, out_drid} !== '0) begin n_bad++; $display("FAIL reset_out: got %h %h %h %h %h %h want 0", out_data, out_addr, out_npc, out_aluresult, out_ir, out_drid); end
      reset = 1'b0;
   endtask

   task automatic test_ld_wait();
      run_txn(MOP_LD, 16'h3001, 16'h0, 16'h1111, 16'h2222, 16'h3333, 3'd2, 3, 0, 16'hBEEF, 16'h0, 1'b1);
      n_vec++; if (obs_addr[0] !== 16'h3000) begin n_bad++; $display("FAIL ld_addr: got %h want 3000", obs_addr[0]); end
      n_vec++; if (obs_be[0] !== 2'b11 || obs_rd[0] !== 1'b1) begin n_bad++; $display("FAIL ld_req: got be=%b rd=%b want 11/1", obs_be[0], obs_rd[0]); end
      n_vec++; if (o_data !== 16'hBEEF) begin n_bad++; $display("FAIL ld_data: got %h want beef", o_data); end
      n_vec++; if (obs_lat !== 4) begin n_bad++; $display("FAIL ld_latency: got %0d want 4", obs_lat); end
      n_vec++; if (o_npc !== 16'h1111 || o_drid !== 3'd2) begin n_bad++; $display("FAIL ld_pass: got %h/%0d want 1111/2", o_npc, o_drid); end
      n_vec++; if (obs_unstable || obs_stall_bad || post_valid !== 1'b0 || post_ready !== 1'b1) begin n_bad++; $display("FAIL ld_hs: got unst=%b stall=%b pv=%b pr=%b want 0 0 0 1", obs_unstable, obs_stall_bad, post_valid, post_ready); end
   endtask

   task automatic test_byte();
      run_txn(MOP_LDB, 16'h2005, 16'h0, 16'h0, 16'h0, 16'h0, 3'd1, 1, 0, 16'h8A7F, 16'h0, 1'b0);
      n_vec++; if (obs_be[0] !== 2'b10) begin n_bad++; $display("FAIL ldb_be: got %b want 10", obs_be[0]); end
      n_vec++; if (o_data !== 16'h008A) begin n_bad++; $display("FAIL ldb_data: got %h want 008a", o_data); end
      run_txn(MOP_STB, 16'h2004, 16'h1234, 16'h0, 16'h0, 16'h0, 3'd1, 0, 0, 16'hFFFF, 16'h0, 1'b0);
      n_vec++; if (obs_wd[0] !== 16'h3434 || obs_be[0] !== 2'b01) begin n_bad++; $display("FAIL stb_req: got %h/%b want 3434/01", obs_wd[0], obs_be[0]); end
      n_vec++; if (obs_wr[0] !== 1'b1 || o_data !== 16'h0) begin n_bad++; $display("FAIL stb_res: got wr=%b data=%h want 1/0000", obs_wr[0], o_data); end
   endtask

   task automatic test_sti();
      run_txn(MOP_STI, 16'h4000, 16'h5555, 16'h0, 16'h0, 16'h0, 3'd0, 0, 2, 16'h6003, 16'h0, 1'b0);
      n_vec++; if (obs_rd[0] !== 1'b1 || obs_addr[0] !== 16'h4000) begin n_bad++; $display("FAIL sti_ptr_rd: got rd=%b %h want 1 4000", obs_rd[0], obs_addr[0]); end
      n_vec++; if (obs_wr[1] !== 1'b1 || obs_addr[1] !== 16'h6002 || obs_wd[1] !== 16'h5555) begin n_bad++; $display("FAIL sti_wr: got wr=%b %h %h want 1 6002 5555", obs_wr[1], obs_addr[1], obs_wd[1]); end
      n_vec++; if (o_addr !== 16'h6002) begin n_bad++; $display("FAIL sti_out_addr: got %h want 6002", o_addr); end
      n_vec++; if (obs_stall_bad || obs_nacc !== 2) begin n_bad++; $display("FAIL sti_stall: got bad=%b nacc=%0d want 0/2", obs_stall_bad, obs_nacc); end
   endtask

   task automatic test_timeout();
      run_txn(MOP_LD, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 3'd3, 99, 0, 16'hAAAA, 16'h0, 1'b0);
      n_vec++; if (o_err !== 1'b1 || o_data !== 16'h0) begin n_bad++; $display("FAIL to_err: got err=%b data=%h want 1/0000", o_err, o_data); end
      n_vec++; if (obs_len[0] !== 4 || obs_lat !== 4) begin n_bad++; $display("FAIL to_len: got len=%0d lat=%0d want 4/4", obs_len[0], obs_lat); end
      run_txn(MOP_LD, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 3'd3, 3, 0, 16'h1357, 16'h0, 1'b0);
      n_vec++; if (o_err !== 1'b0 || o_data !== 16'h1357) begin n_bad++; $display("FAIL to_edge: got err=%b data=%h want 0/1357", o_err, o_data); end
   endtask

   task automatic test_reset_midflight();
      in_valid = 1'b1; in_op = MOP_LDI; in_addr = 16'h1000; in_drid = 3'd4;
      tick();
      in_valid = 1'b0;
      mem_resp = 1'b1; mem_rdata = 16'h2222;
      tick();
      mem_resp = 1'b0;
      n_vec++; if (mem_read !== 1'b1 || mem_address !== 16'h2222) begin n_bad++; $display("FAIL rst_acc2: got rd=%b %h want 1 2222", mem_read, mem_address); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_vec++; if ({mem_read, mem_write, out_valid, in_ready} !== 4'b0001) begin n_bad++; $display("FAIL rst_abort: got %b want 0001", {mem_read, mem_write, out_valid, in_ready}); end
      for (int c = 0; c < 4; c++) begin
         n_vec++; if (out_valid !== 1'b0 || mem_read !== 1'b0) begin n_bad++; $display("FAIL rst_quiet%0d: got v=%b rd=%b want 0/0", c, out_valid, mem_read); end
         tick();
      end
      run_txn(MOP_LD, 16'h0042, 16'h0, 16'h0, 16'h0, 16'h0, 3'd6, 1, 0, 16'hC0DE, 16'h0, 1'b0);
      n_vec++; if (obs_valid !== 1'b1 || o_data !== 16'hC0DE || obs_lat !== 2) begin n_bad++; $display("FAIL rst_after_ld: got v=%b %h lat=%0d want 1 c0de 2", obs_valid, o_data, obs_lat); end
   endtask

   task automatic test_none();
      run_txn(MOP_NONE, 16'h0777, 16'h0, 16'h0ABC, 16'h00FF, 16'h1234, 3'd5, 0, 0, 16'h0, 16'h0, 1'b0);
      n_vec++; if (obs_lat !== 0) begin n_bad++; $display("FAIL none_lat: got %0d want 0", obs_lat); end
      n_vec++; if (o_alu !== 16'h00FF || o_drid !== 3'd5 || o_ir !== 16'h1234) begin n_bad++; $display("FAIL none_pass: got %h/%0d/%h want 00ff/5/1234", o_alu, o_drid, o_ir); end
      n_vec++; if (obs_nacc !== 0) begin n_bad++; $display("FAIL none_mem: got %0d accesses want 0", obs_nacc); end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [15:0] addr, wd, npc, alu, ir, r1, r2;
      logic [2:0]  drid;
      int d1, d2;
      bit byte_op;
      for (int i = 0; i < 150; i++) begin
         op = 3'($urandom_range(0, 6)); addr = 16'($urandom); wd = 16'($urandom);
         npc = 16'($urandom); alu = 16'($urandom); ir = 16'($urandom); drid = 3'($urandom);
         r1 = 16'($urandom); r2 = 16'($urandom);
         d1 = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
         d2 = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
         byte_op = (op == MOP_LDB) || (op == MOP_STB);
         predict(op, addr, wd, d1, d2, r1, r2);
         run_txn(op, addr, wd, npc, alu, ir, drid, d1, d2, r1, r2, 1'($urandom));
         n_vec++; if (obs_valid !== 1'b1 || obs_lat !== exp_lat) begin n_bad++; $display("FAIL rnd%0d lat: got v=%b %0d want %0d", i, obs_valid, obs_lat, exp_lat); end
         n_vec++; if (obs_nacc !== exp_nacc || obs_extra) begin n_bad++; $display("FAIL rnd%0d nacc: got %0d want %0d", i, obs_nacc, exp_nacc); end
         for (int k = 0; k < exp_nacc; k++) begin
            n_vec++; if (obs_rd[k] !== exp_rd[k] || obs_wr[k] !== exp_wr[k] || obs_be[k] !== exp_be[k] || obs_len[k] !== exp_len[k]) begin n_bad++; $display("FAIL rnd%0d acc%0d: got rd=%b wr=%b be=%b len=%0d want %b %b %b %0d", i, k, obs_rd[k], obs_wr[k], obs_be[k], obs_len[k], exp_rd[k], exp_wr[k], exp_be[k], exp_len[k]); end
            if (!byte_op) begin
               n_vec++; if (obs_addr[k] !== exp_addr[k]) begin n_bad++; $display("FAIL rnd%0d addr%0d: got %h want %h", i, k, obs_addr[k], exp_addr[k]); end
            end
            if (exp_wr[k]) begin
               n_vec++; if (obs_wd[k] !== exp_wd[k]) begin n_bad++; $display("FAIL rnd%0d wdata%0d: got %h want %h", i, k, obs_wd[k], exp_wd[k]); end
            end
         end
         n_vec++; if (o_data !== exp_data || o_err !== exp_err) begin n_bad++; $display("FAIL rnd%0d result: got %h err=%b want %h err=%b", i, o_data, o_err, exp_data, exp_err); end
         if (!byte_op && op != MOP_NONE) begin
            n_vec++; if (o_addr !== exp_oaddr) begin n_bad++; $display("FAIL rnd%0d out_addr: got %h want %h", i, o_addr, exp_oaddr); end
         end
         n_vec++; if (o_npc !== npc || o_alu !== alu || o_ir !== ir || o_drid !== drid) begin n_bad++; $display("FAIL rnd%0d pass: got %h %h %h %0d want %h %h %h %0d", i, o_npc, o_alu, o_ir, o_drid, npc, alu, ir, drid); end
         n_vec++; if (obs_stall_bad || obs_unstable || obs_both || post_valid !== 1'b0 || post_ready !== 1'b1) begin n_bad++; $display("FAIL rnd%0d hs: got stall=%b unst=%b both=%b pv=%b pr=%b want 0 0 0 0 1", i, obs_stall_bad, obs_unstable, obs_both, post_valid, post_ready); end
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_op = '0; in_addr = '0; in_wdata = '0; in_npc = '0;
      in_aluresult = '0; in_ir = '0; in_drid = '0; mem_rdata = '0; mem_resp = 1'b0;
      tick();
      test_reset();
      test_ld_wait();
      test_byte();
      test_sti();
      test_timeout();
      test_reset_midflight();
      test_none();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Parametrised LC-3b MEM pipeline stage that drives a real memory handshake and registers the result into the MEM/WB boundary. Handles word, byte, and indirect (LDI/STI) accesses, with multi-cycle memory waits and an optional response timeout. Sits between the EX/MEM register and writeback, and asserts a stall to upstream stages while an access is in flight.

Parameters:
DATA_W, 16, data/word width; must be a multiple of 8
ADDR_W, 16, address width
ENABLE_INDIRECT, 1, 1 = LDI/STI perform two accesses; 0 = LDI/STI behave as LD/ST
MAX_WAIT, 0, max cycles awaiting mem_resp per access; 0 = no timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  instruction present from EX/MEM
in_op  in  3  lc3b_mem_op
in_addr  in  ADDR_W  effective address
in_wdata  in  DATA_W  store data
in_npc  in  ADDR_W  passthrough
in_aluresult  in  DATA_W  passthrough
in_ir  in  16  passthrough
in_drid  in  3  destination register id
in_ready  out  1  stage can accept
stall_out  out  1  = !in_ready
mem_read  out  1  read request
mem_write  out  1  write request
mem_address  out  ADDR_W  request address
mem_wdata  out  DATA_W  write data
mem_byte_enable  out  DATA_W/8  lane enables
mem_rdata  in  DATA_W  read data
mem_resp  in  1  access complete
out_valid  out  1  result valid, one-cycle pulse
out_data  out  DATA_W  load result; 0 for stores
out_addr  out  ADDR_W  final access address
out_npc, out_aluresult, out_ir, out_drid  out  as inputs  registered passthrough
out_err  out  1  access aborted by timeout

Behaviour:
- Reset: state IDLE. All outputs 0 except in_ready=1. Wait counter = 0. Reset in any state aborts the access; mem_read/mem_write are low after that edge; no out_valid is produced for the aborted instruction.
- States:
  - IDLE: in_ready=1. in_valid with op NONE: passthroughs captured; out_valid=1 next cycle; no memory traffic.
  - IDLE, in_valid with a memory op: capture all inputs, go to ACC1.
  - ACC1: first access. Word op: address low bits forced 0, byte_enable all ones. Byte op: enable only lane addr[log2(DATA_W/8)-1:0].
  - ACC1, mem_resp: LD/LDB/ST/STB go to DONE. LDI/STI with ENABLE_INDIRECT=1 latch the pointer (mem_rdata, low bits cleared) and go to ACC2.
  - ACC2: second access at the pointer; read for LDI, write for STI. mem_resp goes to DONE.
  - DONE: out_valid=1 for exactly one cycle; return to IDLE. in_ready=0 in DONE, so no back-to-back capture.
- ACC1 and ACC2 assert mem_read or mem_write from registered state, never both. Requests hold steady until mem_resp. mem_resp outside ACC1/ACC2 is ignored.
- Latency: memory op accepted at edge T; request visible cycle T+1; with mem_resp at cycle R, out_valid is at R+1. NONE ops: out_valid at T+1.
- LDI/STI first access is always a word read, even for STI.
- LDB result: selected byte zero-extended to DATA_W. STB: mem_wdata = in_wdata[7:0] replicated on every lane.
- Word loads: out_data = mem_rdata.
- Timeout: counter increments on each ACC cycle without mem_resp and clears on entering an ACC state. If it reaches MAX_WAIT (and MAX_WAIT>0), drop the request, go to DONE with out_err=1 and out_data=0. mem_resp arriving in the same cycle as the timeout wins: normal completion.
- in_valid while in_ready=0 is ignored; upstream holds via stall_out.

Decomposition:
- lc3b_types package adds:
  - lc3b_mem_op enum: MOP_NONE=0, MOP_LD=1, MOP_ST=2, MOP_LDB=3, MOP_STB=4, MOP_LDI=5, MOP_STI=6
  - mem_state enum: IDLE, ACC1, ACC2, DONE
- One sub-module, mem_byte_lane: given address low bits, op, wdata, and rdata, it produces byte_enable, the replicated store data, and the extended load data. It is purely combinational.

Test Plan:
- LD addr 0x3001, mem_resp after 3 wait cycles with rdata 0xBEEF: mem_address 0x3000, byte_enable 2'b11, out_data 0xBEEF, out_valid 4 cycles after the first request cycle.
- LDB addr 0x2005, rdata 0x8A7F: byte_enable 2'b10, out_data 0x008A. STB addr 0x2004, wdata 0x1234: mem_wdata 0x3434, byte_enable 2'b01.
- STI addr 0x4000, wdata 0x5555, first rdata 0x6003: read at 0x4000, then write 0x5555 at 0x6002; out_addr 0x6002; stall_out high throughout.
- MAX_WAIT=4, no mem_resp: request drops after 4 wait cycles; out_valid with out_err=1, out_data 0. Repeat with mem_resp exactly on the 4th cycle: out_err=0.
- reset asserted in ACC2 of an LDI: next cycle mem_read=0, state IDLE, in_ready=1, no out_valid. A following LD then completes normally.
- MOP_NONE with aluresult 0x00FF, drid 5: out_valid next cycle, out_aluresult 0x00FF, out_drid 5, mem_read=mem_write=0.
